register_writeback: RTL

- Write-side client of the 8 x 16-bit register set.
- Accepts ALU/load results (destination register plus data) over a valid/ready handshake and buffers them in a small in-order queue.
- Drains one entry per cycle into the register set write port.
- Provides read-after-write forwarding for the two operand selects (x, y), so operand fetch sees results that have not yet been written.

---
 rtl/register_writeback_pkg.sv | 27 ++
 rtl/register_writeback_forward.sv | 34 +++
 rtl/register_writeback.sv | 104 ++++++++++
 3 files changed

// File: rtl/register_writeback_pkg.sv
// Shared widths and queue entry layout for the register set write-back path.
package register_writeback_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned SEL_W    = 3;
  localparam int unsigned NUM_REGS = 8;

  // One pending write: destination register plus data, tagged valid while queued.
  typedef struct packed {
    logic              valid;
    logic [SEL_W-1:0]  reg_sel;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  localparam wb_entry_t WB_ENTRY_EMPTY = '0;

  // Make a queued entry from a producer result.
  function automatic wb_entry_t make_entry(input logic [SEL_W-1:0] reg_sel,
                                           input logic [DATA_W-1:0] data);
    wb_entry_t e;
    e.valid   = 1'b1;
    e.reg_sel = reg_sel;
    e.data    = data;
    return e;
  endfunction

endpackage

// File: rtl/register_writeback_forward.sv
// Youngest-match search over the pending write queue for one operand select.
module writeback_forward
  import register_writeback_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  wb_entry_t         entries [DEPTH],
  input  logic [PTR_W-1:0]  rd_ptr,
  input  logic [CNT_W-1:0]  count,
  input  logic [SEL_W-1:0]  select,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = PTR_W'(rd_ptr + PTR_W'(i));
      if ((CNT_W'(i) < count) && entries[idx].valid &&
          (entries[idx].reg_sel == select)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/register_writeback.sv
// Write-side client of the 8 x 16-bit register set: in-order result queue,
// one drain per cycle into the write port, and read-after-write forwarding.
module register_writeback
  import register_writeback_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [SEL_W-1:0]  res_reg,
  input  logic [DATA_W-1:0] res_data,
  input  logic              wr_hold,
  output logic              wr_enable,
  output logic [SEL_W-1:0]  wr_reg,
  output logic [DATA_W-1:0] wr_data,
  input  logic [SEL_W-1:0]  x_select,
  input  logic [SEL_W-1:0]  y_select,
  output logic              x_fwd_hit,
  output logic [DATA_W-1:0] x_fwd_data,
  output logic              y_fwd_hit,
  output logic [DATA_W-1:0] y_fwd_data,
  output logic [SEL_W-1:0]  pending_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  wb_entry_t        entries [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  logic             empty;
  logic             full;
  wb_entry_t        head;

  // Occupancy flags come from the count, so pointer equality is never ambiguous.
  always_comb begin
    empty = (count == '0);
    full  = (count == CNT_W'(DEPTH));
    head  = entries[rd_ptr];
  end

  // Handshake and drain strobes; res_ready depends on registered state only.
  always_comb begin
    res_ready     = !full;
    push          = res_valid && !full;
    wr_enable     = !empty && !wr_hold;
    pop           = wr_enable;
    wr_reg        = empty ? '0 : head.reg_sel;
    wr_data       = empty ? '0 : head.data;
    pending_count = SEL_W'(count);
  end

  // Queue storage, pointers and occupancy; reset discards everything queued.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries[i] <= WB_ENTRY_EMPTY;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop) begin
        entries[rd_ptr].valid <= 1'b0;
        rd_ptr                <= PTR_W'(rd_ptr + PTR_W'(1));
      end
      if (push) begin
        entries[wr_ptr] <= make_entry(res_reg, res_data);
        wr_ptr          <= PTR_W'(wr_ptr + PTR_W'(1));
      end
      case ({push, pop})
        2'b10:   count <= CNT_W'(count + CNT_W'(1));
        2'b01:   count <= CNT_W'(count - CNT_W'(1));
        default: count <= count;
      endcase
    end
  end

  // Operand x forwarding.
  writeback_forward #(.DEPTH(DEPTH)) u_fwd_x (
    .entries (entries),
    .rd_ptr  (rd_ptr),
    .count   (count),
    .select  (x_select),
    .hit     (x_fwd_hit),
    .data    (x_fwd_data)
  );

  // Operand y forwarding.
  writeback_forward #(.DEPTH(DEPTH)) u_fwd_y (
    .entries (entries),
    .rd_ptr  (rd_ptr),
    .count   (count),
    .select  (y_select),
    .hit     (y_fwd_hit),
    .data    (y_fwd_data)
  );

endmodule
